// File: rtl/ram_port_responder.sv
// On-chip RAM responder for the simple mm2s read / s2mm write memory ports.
// Serves one read and one write port with LFSR-driven wait states and a fixed read latency.
module ram_port_responder #(
    parameter int          AXI_WIDTH      = 128,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          DEPTH          = 1024,
    parameter int          RD_LAT         = 2,
    parameter int          WAIT_THRESH    = 0,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic                      rd_wait,
    output logic [AXI_WIDTH-1:0]      rd_data,
    output logic                      rd_ack,
    input  logic                      wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_addr,
    input  logic [AXI_WIDTH-1:0]      wr_data,
    input  logic [AXI_WIDTH/8-1:0]    wr_strb,
    output logic                      wr_wait,
    output logic                      wr_ack,
    output logic                      err
);
    localparam int          STRB_W    = AXI_WIDTH / 8;
    localparam int          OFFSET    = $clog2(STRB_W);
    localparam int          IDX_W     = AXI_ADDR_WIDTH - OFFSET;
    localparam int          RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] WR_SEED   = SEED ^ 16'h5A5A;
    localparam logic [8:0]  THRESH    = 9'(WAIT_THRESH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    // Fibonacci LFSR, taps 16,14,13,11 (maximal length)
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [AXI_WIDTH-1:0] mem_r [DEPTH];

    logic [15:0]          rd_lfsr_r;
    logic [15:0]          wr_lfsr_r;
    logic                 rd_wait_r;
    logic                 wr_wait_r;
    logic                 wr_ack_r;
    logic                 err_r;
    logic [RD_LAT-1:0]    rd_vld_r;
    logic [AXI_WIDTH-1:0] rd_dat_r [RD_LAT];

    logic [IDX_W-1:0]     rd_idx_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic                 rd_oob_s;
    logic                 wr_oob_s;
    logic                 rd_accept_s;
    logic                 wr_accept_s;
    logic [AXI_WIDTH-1:0] rd_mem_s;
    logic                 unused_addr_s;

    // Address decode, acceptance and read-first RAM lookup
    always_comb begin
        rd_idx_s      = rd_addr[AXI_ADDR_WIDTH-1:OFFSET];
        wr_idx_s      = wr_addr[AXI_ADDR_WIDTH-1:OFFSET];
        rd_oob_s      = (rd_idx_s >= DEPTH_IDX);
        wr_oob_s      = (wr_idx_s >= DEPTH_IDX);
        rd_accept_s   = rd_en && !rd_wait_r;
        wr_accept_s   = wr_en && !wr_wait_r;
        rd_mem_s      = rd_oob_s ? {AXI_WIDTH{1'b0}} : mem_r[rd_idx_s[RAM_AW-1:0]];
        unused_addr_s = ^{rd_addr, wr_addr};
    end

    // Per-port LFSRs; next-cycle wait comes from the current LFSR state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lfsr_r <= SEED;
            wr_lfsr_r <= WR_SEED;
            rd_wait_r <= 1'b1;
            wr_wait_r <= 1'b1;
        end else begin
            rd_lfsr_r <= lfsr_step(rd_lfsr_r);
            wr_lfsr_r <= lfsr_step(wr_lfsr_r);
            rd_wait_r <= ({1'b0, rd_lfsr_r[7:0]} < THRESH);
            wr_wait_r <= ({1'b0, wr_lfsr_r[7:0]} < THRESH);
        end
    end

    // Read valid/data shift pipeline; each stage holds data until new valid data arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                rd_dat_r[i] <= {AXI_WIDTH{1'b0}};
            end
        end else begin
            rd_vld_r[0] <= rd_accept_s;
            if (rd_accept_s) begin
                rd_dat_r[0] <= rd_mem_s;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_r[i] <= rd_vld_r[i-1];
                if (rd_vld_r[i-1]) begin
                    rd_dat_r[i] <= rd_dat_r[i-1];
                end
            end
        end
    end

    // Write acknowledge and sticky out-of-range flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            wr_ack_r <= wr_accept_s;
            err_r    <= err_r | (rd_accept_s & rd_oob_s) | (wr_accept_s & wr_oob_s);
        end
    end

    // Byte-enabled RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_accept_s && !wr_oob_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_r[wr_idx_s[RAM_AW-1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_wait = rd_wait_r;
    assign wr_wait = wr_wait_r;
    assign rd_ack  = rd_vld_r[RD_LAT-1];
    assign rd_data = rd_dat_r[RD_LAT-1];
    assign wr_ack  = wr_ack_r;
    assign err     = err_r;

endmodule

// File: tb/tb_ram_port_responder.sv
// Directed bench for ram_port_responder: one instance without wait states,
// one with WAIT_THRESH=128 for the randomized in-order read stream.
module tb_ram_port_responder;
    localparam int W  = 128;
    localparam int AW = 32;
    localparam int SW = W / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en, rd_wait, wr_wait, rd_ack, wr_ack, err;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  rd_data, wr_data;
    logic [SW-1:0] wr_strb;

    logic          rd_en2, wr_en2, rd_wait2, wr_wait2, rd_ack2, wr_ack2, err2;
    logic [AW-1:0] rd_addr2, wr_addr2;
    logic [W-1:0]  rd_data2, wr_data2;
    logic [SW-1:0] wr_strb2;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  model2 [16];
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  rdata;
    int            issued, acks, stalls, reqs, cyc, nwait;
    bit            acc, saw_ack;

    always #5 clk = ~clk;

    ram_port_responder #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .DEPTH(1024), .RD_LAT(2),
                         .WAIT_THRESH(0), .SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_wait(rd_wait), .rd_data(rd_data), .rd_ack(rd_ack),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_wait(wr_wait), .wr_ack(wr_ack), .err(err)
    );

    ram_port_responder #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .DEPTH(1024), .RD_LAT(2),
                         .WAIT_THRESH(128), .SEED(16'hACE1)) u_dut_wait (
        .clk(clk), .rst(rst),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_wait(rd_wait2), .rd_data(rd_data2), .rd_ack(rd_ack2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_strb(wr_strb2),
        .wr_wait(wr_wait2), .wr_ack(wr_ack2), .err(err2)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                            input logic [SW-1:0] s, input string tag);
        int n = 0;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        while (wr_wait && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wr_ready"}, W'(wr_wait), 128'd0);
        @(negedge clk);
        wr_en = 1'b0;
        chk({tag, "_wr_ack"}, W'(wr_ack), 128'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag, output logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        while (rd_wait && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rd_ready"}, W'(rd_wait), 128'd0);
        @(negedge clk);
        rd_en = 1'b0;
        chk({tag, "_ack_early"}, W'(rd_ack), 128'd0);
        @(negedge clk);
        chk({tag, "_ack"}, W'(rd_ack), 128'd1);
        d = rd_data;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, W'(rd_ack), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en2 = 1'b0; rd_addr2 = '0; wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; wr_strb2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_wait", W'(rd_wait), 128'd1);
        chk("rst_wr_wait", W'(wr_wait), 128'd1);
        chk("rst_rd_ack", W'(rd_ack), 128'd0);
        chk("rst_wr_ack", W'(wr_ack), 128'd0);
        chk("rst_err", W'(err), 128'd0);
        chk("rst_rd_data", rd_data, 128'd0);
        chk("rst_waits2", W'({rd_wait2, wr_wait2}), 128'd3);
        rst = 1'b0;

        // basic write then read, plus unaligned read of the same word
        do_write(32'h40, 128'h0011_2233, {SW{1'b1}}, "t1");
        do_read(32'h40, "t1", rdata);
        chk("t1_data", rdata, 128'h0011_2233);
        chk("t1_hold", rd_data, 128'h0011_2233);
        do_read(32'h4B, "t1u", rdata);
        chk("t1u_data", rdata, 128'h0011_2233);

        // byte strobes
        do_write(32'h40, 128'd0, {SW{1'b1}}, "t2c");
        do_write(32'h40, {{15{8'h55}}, 8'hFF}, 16'h0001, "t2");
        do_read(32'h40, "t2", rdata);
        chk("t2_data", rdata, 128'h0000_00FF);
        do_write(32'h40, {16{8'hAB}}, 16'h0100, "t2m");
        do_write(32'h40, {W{1'b1}}, 16'h0000, "t2z");
        do_read(32'h40, "t2m", rdata);
        chk("t2m_data", rdata, 128'h00000000_000000AB_00000000_000000FF);

        // same-edge read and write: read-first
        do_write(32'h80, 128'hA, {SW{1'b1}}, "t3a");
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 32'h80;
        wr_en = 1'b1; wr_addr = 32'h80; wr_data = 128'hB; wr_strb = {SW{1'b1}};
        chk("t3_ready", W'({rd_wait, wr_wait}), 128'd0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        chk("t3_wr_ack", W'(wr_ack), 128'd1);
        @(negedge clk);
        chk("t3_rd_ack", W'(rd_ack), 128'd1);
        chk("t3_old", rd_data, 128'hA);
        do_read(32'h80, "t3n", rdata);
        chk("t3_new", rdata, 128'hB);

        // back-to-back reads, one per cycle
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 32'h40;
        @(negedge clk);
        rd_addr = 32'h80;
        @(negedge clk);
        rd_en = 1'b0;
        chk("bb_ack1", W'(rd_ack), 128'd1);
        chk("bb_data1", rd_data, 128'h00000000_000000AB_00000000_000000FF);
        @(negedge clk);
        chk("bb_ack2", W'(rd_ack), 128'd1);
        chk("bb_data2", rd_data, 128'hB);
        @(negedge clk);
        chk("bb_ack3", W'(rd_ack), 128'd0);

        // address range edges
        chk("t5_err_pre", W'(err), 128'd0);
        do_write(32'h0, 128'hC0FFEE, {SW{1'b1}}, "t5w0");
        do_write(32'h3FF0, 128'h77, {SW{1'b1}}, "t5top");
        do_read(32'h3FF0, "t5top", rdata);
        chk("t5_top_data", rdata, 128'h77);
        chk("t5_top_err", W'(err), 128'd0);
        do_read(32'h4000, "t5oob", rdata);
        chk("t5_oob_data", rdata, 128'd0);
        chk("t5_oob_err", W'(err), 128'd1);
        do_write(32'h4000, 128'hDEAD, {SW{1'b1}}, "t5oobw");
        chk("t5_err_sticky", W'(err), 128'd1);
        do_read(32'h0, "t5r0", rdata);
        chk("t5_word0", rdata, 128'hC0FFEE);

        // reset with a read in flight
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 32'h80;
        @(negedge clk);
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rd_wait", W'(rd_wait), 128'd1);
        chk("t6_wr_wait", W'(wr_wait), 128'd1);
        chk("t6_err", W'(err), 128'd0);
        chk("t6_rd_data", rd_data, 128'd0);
        saw_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_ack = saw_ack | rd_ack;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_ack = saw_ack | rd_ack;
        end
        chk("t6_no_ack", W'(saw_ack), 128'd0);
        chk("t6_err_after", W'(err), 128'd0);
        do_read(32'h80, "t6r", rdata);
        chk("t6_ram_kept", rdata, 128'hB);

        // randomized reads against wait states on the second instance
        for (int w = 0; w < 16; w++) begin
            model2[w] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            wr_en2 = 1'b1; wr_addr2 = 32'(w * 16); wr_data2 = model2[w]; wr_strb2 = {SW{1'b1}};
            nwait = 0;
            while (wr_wait2 && nwait < 100) begin
                @(negedge clk);
                nwait++;
            end
            chk("t4_wr_ready", W'(wr_wait2), 128'd0);
            @(negedge clk);
            wr_en2 = 1'b0;
            chk("t4_wr_ack", W'(wr_ack2), 128'd1);
        end
        issued = 0; acks = 0; stalls = 0; reqs = 0; cyc = 0;
        @(negedge clk);
        rd_en2 = 1'b1; rd_addr2 = 32'($urandom_range(0, 255));
        while (acks < 1000 && cyc < 20000) begin
            acc = 1'b0;
            if (rd_en2) begin
                reqs++;
                if (rd_wait2) begin
                    stalls++;
                end else begin
                    exp_q.push_back(model2[rd_addr2[7:4]]);
                    issued++;
                    acc = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            if (rd_ack2) begin
                acks++;
                chk("t4_ack_expected", W'(exp_q.size() > 0), 128'd1);
                if (exp_q.size() > 0) begin
                    chk("t4_data", rd_data2, exp_q.pop_front());
                end
            end
            if (acc) begin
                if (issued < 1000) begin
                    rd_addr2 = 32'($urandom_range(0, 255));
                end else begin
                    rd_en2 = 1'b0;
                end
            end
        end
        rd_en2 = 1'b0;
        chk("t4_acks", W'(acks), 128'd1000);
        chk("t4_issued", W'(issued), 128'd1000);
        chk("t4_queue_empty", W'(exp_q.size()), 128'd0);
        chk("t4_stall_frac", W'((stalls * 100 >= reqs * 40) && (stalls * 100 <= reqs * 60)), 128'd1);
        chk("t4_err", W'(err2), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
